// File: rtl/dram_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dram_access_ctrl_if
//   Bundle of the requester-side handshake and the DRAM-side bus that surround
//   dram_access_ctrl.
//
//   Requester side (two ports, index 0 = CPU, index 1 = debug/loader):
//     req_valid[p], req_ready[p]  request handshake
//     req_we[p], req_op[p], req_unsigned[p], req_addr[p], req_wdata[p]
//     rsp_valid[p]                one-cycle response pulse to the owner
//     rsp_rdata, rsp_err          shared response payload
//   DRAM side:
//     mem_addr (word index), mem_we, mem_wdata, mem_rdata (async read)
//
//   Modports:
//     master : the environment (requesters plus the DRAM itself)
//     slave  : the access controller
// -----------------------------------------------------------------------------
interface dram_access_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0][1:0]        req_op;
    logic [1:0]             req_unsigned;
    logic [1:0][31:0]       req_addr;
    logic [1:0][31:0]       req_wdata;
    logic [1:0]             rsp_valid;
    logic [31:0]            rsp_rdata;
    logic                   rsp_err;
    logic [ADDR_W-3:0]      mem_addr;
    logic                   mem_we;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem_rdata;

    modport master (
        output req_valid, req_we, req_op, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_op, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dram_access_ctrl.sv
// -----------------------------------------------------------------------------
// dram_access_ctrl
//   Sequencer/arbiter in front of a single-port word-organised data DRAM
//   (async read, write on posedge clk). Two requesters share the DRAM with
//   round-robin arbitration. Loads return the addressed byte/halfword/word,
//   sign- or zero-extended. Word stores write directly; byte/halfword stores
//   are done as read-modify-write.
//
//   Ports:
//     clk    system clock, all state changes on posedge
//     rst_n  synchronous active-low reset
//     bus    dram_access_ctrl_if.slave (requester handshake + DRAM bus)
//
//   Timing from the accept edge T (end of the IDLE cycle with req_ready high):
//     T+1 ACCESS : word store writes here; loads sample mem_rdata here
//     T+2 WRITE  : sub-word store writes the merged word here
//     RESP       : T+2 for loads/word stores/errors, T+3 for sub-word stores
// -----------------------------------------------------------------------------
module dram_access_ctrl #(
    parameter int         ADDR_W = 16,
    parameter logic [1:0] OP_B   = 2'd0,
    parameter logic [1:0] OP_H   = 2'd1,
    parameter logic [1:0] OP_W   = 2'd2
) (
    input  logic              clk,
    input  logic              rst_n,
    dram_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Misaligned halfword/word or an undefined op code.
    function automatic logic op_err(input logic [1:0] op, input logic [1:0] lane);
        logic e;
        e = 1'b1;
        if (op == OP_B) begin
            e = 1'b0;
        end else if (op == OP_H) begin
            e = lane[0];
        end else if (op == OP_W) begin
            e = (lane != 2'b00);
        end
        return e;
    endfunction

    // Pick the addressed lane out of a DRAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  op,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        if (op == OP_B) begin
            r = uns ? {24'd0, b} : 32'(b);
        end else if (op == OP_H) begin
            r = uns ? {16'd0, h} : 32'(h);
        end else begin
            r = word;
        end
        return r;
    endfunction

    // Replace only the addressed byte/halfword lane of the old word.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  op,
                                               input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        if (op == OP_B) begin
            case (lane)
                2'd0:    r[7:0]   = wdata[7:0];
                2'd1:    r[15:8]  = wdata[7:0];
                2'd2:    r[23:16] = wdata[7:0];
                default: r[31:24] = wdata[7:0];
            endcase
        end else if (op == OP_H) begin
            if (lane[1]) begin
                r[31:16] = wdata[15:0];
            end else begin
                r[15:0]  = wdata[15:0];
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [1:0]        op_q;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [1:0]        rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic              mem_we_q;
    logic [31:0]       mem_wdata_q;

    // -------------------------------------------------------------------------
    // IDLE arbitration (combinational grant, acted on at the accept edge)
    // -------------------------------------------------------------------------
    logic        grant_vld_d;
    logic        grant_port_d;
    logic [1:0]  sel_op_d;
    logic [31:0] sel_addr_d;
    logic        sel_err_d;

    always_comb begin
        grant_vld_d  = 1'b0;
        grant_port_d = 1'b0;
        case (bus.req_valid)
            2'b01: begin
                grant_vld_d  = 1'b1;
                grant_port_d = 1'b0;
            end
            2'b10: begin
                grant_vld_d  = 1'b1;
                grant_port_d = 1'b1;
            end
            2'b11: begin
                // Contention: the port that did not win last time goes next.
                grant_vld_d  = 1'b1;
                grant_port_d = ~last_grant_q;
            end
            default: begin
                grant_vld_d  = 1'b0;
                grant_port_d = 1'b0;
            end
        endcase
        sel_op_d   = bus.req_op[grant_port_d];
        sel_addr_d = bus.req_addr[grant_port_d];
        sel_err_d  = op_err(sel_op_d, sel_addr_d[1:0]);
    end

    assign bus.req_ready = (rst_n && (state_q == IDLE) && grant_vld_d)
                         ? (grant_port_d ? 2'b10 : 2'b01) : 2'b00;

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= 2'd0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            lane_q       <= 2'd0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= 32'd0;
            rsp_err_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 32'd0;
        end else begin
            rsp_valid_q <= 2'b00;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        owner_q      <= grant_port_d;
                        last_grant_q <= grant_port_d;
                        op_q         <= sel_op_d;
                        we_q         <= bus.req_we[grant_port_d];
                        uns_q        <= bus.req_unsigned[grant_port_d];
                        lane_q       <= sel_addr_d[1:0];
                        wdata_q      <= bus.req_wdata[grant_port_d];
                        err_q        <= sel_err_d;
                        // The DRAM bus is set up on the accept edge so that
                        // the ACCESS cycle already sees the right word and a
                        // word store commits at the end of ACCESS.
                        if (!sel_err_d) begin
                            mem_addr_q <= sel_addr_d[ADDR_W-1:2];
                            if (bus.req_we[grant_port_d] && (sel_op_d == OP_W)) begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= bus.req_wdata[grant_port_d];
                            end
                        end
                        state_q <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (err_q) begin
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'd0;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end else if (!we_q) begin
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= load_extract(bus.mem_rdata, op_q, lane_q, uns_q);
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end else if (op_q == OP_W) begin
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end else begin
                        // Read half of the read-modify-write: the old word is
                        // merged as it is captured, so the write data register
                        // doubles as the merge buffer for the WRITE cycle.
                        mem_wdata_q <= merge_lane(bus.mem_rdata, wdata_q, op_q, lane_q);
                        mem_we_q    <= 1'b1;
                        state_q     <= WRITE;
                    end
                end

                WRITE: begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    // Reset blocks the DRAM write in the very cycle it is asserted.
    assign bus.mem_we    = mem_we_q & rst_n;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dram_access_ctrl.sv
module tb_dram_access_ctrl;

    localparam logic [1:0] OPB = 2'd0;
    localparam logic [1:0] OPH = 2'd1;
    localparam logic [1:0] OPW = 2'd2;
    localparam logic [1:0] OPX = 2'd3;

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  op;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_access_ctrl_if #(.ADDR_W(16)) bus();

    dram_access_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // DRAM model: async read, write on posedge.
    logic [31:0] mem [0:16383];
    int wr_count = 0;
    int wr_cyc   = -1;
    int cyc      = 0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    bit   grant_q[$];
    int   last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Response monitor / scoreboard pop.
    exp_t mon_e;
    always @(negedge clk) begin
        if (bus.mem_we) wr_cyc = cyc;
        if (bus.rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=rsp_valid %b required=none (cycle %0d)", bus.rsp_valid, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_owner", 32'(bus.rsp_valid), mon_e.port ? 32'd2 : 32'd1);
                chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                chk("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    // Drive one request, wait (bounded) for acceptance, push the expectation.
    // Called just after a posedge; returns just after the accept edge with
    // req_valid still high.
    task automatic issue(input vec_t v);
        int   n;
        bit   ok;
        exp_t e;
        bus.req_we[v.port]       = v.we;
        bus.req_op[v.port]       = v.op;
        bus.req_unsigned[v.port] = v.uns;
        bus.req_addr[v.port]     = v.addr;
        bus.req_wdata[v.port]    = v.wdata;
        bus.req_valid[v.port]    = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (bus.req_ready[v.port]) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no req_ready port %0d required=accept", v.port);
        end else begin
            e.port  = v.port;
            e.rdata = v.exp_rdata;
            e.err   = v.exp_err;
            e.acc   = cyc;
            e.lat   = (v.we && !v.exp_err && v.op != OPW) ? 3 : 2;
            exp_q.push_back(e);
            grant_q.push_back(v.port);
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    localparam int NVEC = 26;
    vec_t vecs [NVEC];
    vec_t arb0 [4];
    vec_t arb1 [4];

    initial begin
        int wr0;
        int start;
        vec_t v;

        // port, we, op, uns, addr, wdata, exp_rdata, exp_err
        vecs[0]  = '{1'b0, 1'b1, OPW, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, OPW, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, OPB, 1'b0, 32'h12, 32'h55,       32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b0, OPW, 1'b0, 32'h10, 32'h0,        32'hDE55BEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, OPW, 1'b0, 32'h20, 32'h80FF7F01, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 1'b0, OPB, 1'b0, 32'h21, 32'h0,        32'h0000007F, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, OPB, 1'b0, 32'h22, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, OPH, 1'b1, 32'h22, 32'h0,        32'h000080FF, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, OPH, 1'b0, 32'h22, 32'h0,        32'hFFFF80FF, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, OPW, 1'b0, 32'h13, 32'h12345678, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 1'b0, OPH, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b1, 1'b0, OPX, 1'b0, 32'h20, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b1, 1'b1, OPX, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 1'b0, OPW, 1'b0, 32'h20, 32'h0,        32'h80FF7F01, 1'b0};
        vecs[14] = '{1'b0, 1'b0, OPW, 1'b0, 32'h10, 32'h0,        32'hDE55BEEF, 1'b0};
        vecs[15] = '{1'b1, 1'b1, OPW, 1'b0, 32'h30, 32'h11223344, 32'h0,        1'b0};
        vecs[16] = '{1'b1, 1'b1, OPH, 1'b0, 32'h32, 32'hFFFF5678, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 1'b0, OPW, 1'b0, 32'h30, 32'h0,        32'h56783344, 1'b0};
        vecs[18] = '{1'b0, 1'b1, OPB, 1'b0, 32'h33, 32'hFFFFFFA5, 32'h0,        1'b0};
        vecs[19] = '{1'b0, 1'b0, OPB, 1'b1, 32'h33, 32'h0,        32'h000000A5, 1'b0};
        vecs[20] = '{1'b1, 1'b0, OPB, 1'b0, 32'h33, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[21] = '{1'b1, 1'b0, OPH, 1'b1, 32'h30, 32'h0,        32'h00003344, 1'b0};
        vecs[22] = '{1'b0, 1'b1, OPH, 1'b0, 32'h30, 32'h0000BEEF, 32'h0,        1'b0};
        vecs[23] = '{1'b0, 1'b0, OPW, 1'b0, 32'h30, 32'h0,        32'hA578BEEF, 1'b0};
        vecs[24] = '{1'b0, 1'b1, OPB, 1'b0, 32'h30, 32'h11,       32'h0,        1'b0};
        vecs[25] = '{1'b1, 1'b0, OPW, 1'b0, 32'h30, 32'h0,        32'hA578BE11, 1'b0};

        for (int k = 0; k < 4; k++) begin
            arb0[k] = '{1'b0, 1'b0, OPW, 1'b0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0};
            arb1[k] = '{1'b1, 1'b0, OPW, 1'b0, 32'h20, 32'h0, 32'h80FF7F01, 1'b0};
        end

        // ---------------- reset state ----------------
        bus.req_valid    = 2'b11;
        bus.req_we       = 2'b11;
        bus.req_op       = {OPW, OPW};
        bus.req_unsigned = 2'b00;
        bus.req_addr     = {32'h40, 32'h40};
        bus.req_wdata    = {32'h1, 32'h2};
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            v   = vecs[i];
            wr0 = wr_count;
            issue(v);
            bus.req_valid[v.port] = 1'b0;
            drain();
            chk($sformatf("v%0d_write_count", i), 32'(wr_count - wr0),
                (v.we && !v.exp_err) ? 32'd1 : 32'd0);
            if (v.we && !v.exp_err)
                chk($sformatf("v%0d_write_cycle", i), 32'(wr_cyc - last_acc),
                    (v.op == OPW) ? 32'd1 : 32'd2);
        end
        chk("mem_0x10_final", mem[14'h4], 32'hDE55BEEF);
        chk("mem_0x20_final", mem[14'h8], 32'h80FF7F01);
        chk("mem_0x30_final", mem[14'hC], 32'hA578BE11);

        // ---------------- round-robin with both ports busy ----------------
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        grant_q.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) issue(arb0[k]);
                bus.req_valid[0] = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) issue(arb1[k]);
                bus.req_valid[1] = 1'b0;
            end
        join
        drain();
        chk("arb_grant_count", 32'(grant_q.size()), 32'd8);
        for (int k = 0; k < grant_q.size() && k < 8; k++)
            chk($sformatf("arb_grant_%0d", k), 32'(grant_q[k]), 32'(k % 2));

        // ---------------- reset during the WRITE cycle ----------------
        v = '{1'b0, 1'b1, OPW, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0};
        issue(v);
        bus.req_valid[0] = 1'b0;
        drain();
        wr0 = wr_count;
        v = '{1'b0, 1'b1, OPB, 1'b0, 32'h41, 32'h77, 32'h0, 1'b0};
        issue(v);                 // now in the ACCESS cycle
        bus.req_valid[0] = 1'b0;
        @(posedge clk);           // entering WRITE
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstwr_mem_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();           // the aborted store owes no response
        repeat (4) @(negedge clk);
        chk("rstwr_write_count", 32'(wr_count - wr0), 32'd0);
        chk("rstwr_mem_unchanged", mem[14'h10], 32'hCAFEF00D);
        @(posedge clk);
        #1;
        start = cyc;
        v = '{1'b1, 1'b0, OPW, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0};
        issue(v);
        bus.req_valid[1] = 1'b0;
        chk("rstwr_next_accept_cycle", 32'(last_acc - start), 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
